bit_stuff_serializer: RTL
=========================

Name: bit_stuff_serializer

Overview:
Upstream feeder for the NRZI line encoder. Accepts parallel words over a valid/ready handshake and serializes them LSB-first, one bit per clock. After every STUFF_LEN consecutive 1 bits it inserts a 0, which guarantees line transitions downstream. The serial output x connects directly to the encoder's x input on the same clock.

Parameters:
DATA_W, 8, width of each parallel input word
STUFF_LEN, 6, number of consecutive data 1s that forces one stuffed 0

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
data_in  input  DATA_W  parallel word; sampled when data_valid && data_ready
data_valid  input  1  upstream has a word available
data_ready  output  1  block accepts data_in this cycle
x  output  1  serial bit to NRZI encoder; registered
x_valid  output  1  x carries a data or stuff bit this cycle; registered
stuffed  output  1  current x is an inserted stuff bit; registered
busy  output  1  state != IDLE

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, x=1, x_valid=0, stuffed=0, bit_cnt=0, ones_cnt=0. data_ready=1, busy=0.
- Idle line: x=1, x_valid=0. The encoder then holds its level, with no transitions.
- States:
  - IDLE: on accept, go to SHIFT.
  - SHIFT: x = current data bit.
  - STUFF: x = 0, stuffed = 1.
- Accept in cycle T places data_in[0] on x at T+1; data_in[i] appears at T+1+i plus any stuff bits inserted before it.
- ones_cnt: count of consecutive 1 data bits ending with the bit on x. A 0 data bit or a stuff bit clears it.
  - In SHIFT with ones_cnt==STUFF_LEN, the next cycle is STUFF. Afterwards, return to SHIFT at the next data bit, or go to IDLE/next word.
- data_ready (combinational from registers) is high when any of the following holds:
  - state==IDLE;
  - state==SHIFT, bit_cnt==DATA_W-1, and no stuff pending (ones_cnt!=STUFF_LEN);
  - state==STUFF and the stuff follows data bit DATA_W-1.
  - It is low otherwise, and must not depend on data_valid.
- Back-to-back words: a word accepted while the last bit or trailing stuff is on x has its bit 0 on x the next cycle, with no gap. ones_cnt carries across the word boundary, so a stuff can straddle words.
- End of word with no new accept: next cycle is IDLE (x=1, x_valid=0). ones_cnt clears on entering IDLE.
- A stuff bit pending after the last data bit is always emitted before IDLE or the next word.
- data_valid high while data_ready low: no effect. The upstream holds the word.
- Reset mid-word: output returns immediately to the idle values and the partial word is discarded.

Optional Feature:
BIT_STUFF_SYNC_EN:
- Defined: the first accept out of IDLE first emits the sync pattern 0,0,0,0,0,0,0,1 (8 cycles, x_valid=1, stuffed=0, never stuffed) via state SYNC, then the data bits.
  - Data bit 0 appears at T+9.
  - ones_cnt is 1 after the sync.
  - data_ready is low during SYNC.
  - Back-to-back words get no extra sync.
- Undefined: no SYNC state; latency T+1 as above.

Test Plan:
1. Assert reset for 2 cycles, then release -> x=1, x_valid=0, stuffed=0, data_ready=1, busy=0.
2. Accept 0x00 at T, no further valid -> x=0 with x_valid=1 for T+1..T+8; at T+9, x=1, x_valid=0, busy=0.
3. Accept 0xFF alone -> x=1 for T+1..T+6; at T+7, x=0 with stuffed=1; x=1 at T+8..T+9; IDLE at T+10.
4. Accept 0xFF then 0xFF with data_valid held -> 18 contiguous valid bits, no gap: 111111 0 11 1111 0 1111. data_ready is high only at T+9 (second accept).
5. Accept 0xFC (LSB-first 00111111) with the next word waiting -> data_ready low at T+8, stuff at T+9 with data_ready=1; next word's bit 0 at T+10.
6. Drive reset low at T+4 during 0xA5 -> x=1 and x_valid=0 asynchronously. After release, 0x01 serializes cleanly from T'+1 with no leftover bits.

Source files
------------

// File: rtl/bit_stuff_serializer.sv
// ---------------------------------------------------------------------------
// bit_stuff_serializer
//
// Serializer that feeds the NRZI line encoder. Parallel words arrive over a
// valid/ready handshake and leave LSB-first, one bit per clock. After
// STUFF_LEN consecutive 1 data bits a single 0 is inserted so that the
// encoder is guaranteed to produce a line transition. The count of
// consecutive 1s carries across word boundaries, so a stuff bit can fall
// between two back-to-back words.
//
// Optional build macro:
//   BIT_STUFF_SYNC_EN - when defined, the first word accepted out of IDLE is
//                       preceded by the 8-bit sync pattern 0,0,0,0,0,0,0,1
//                       (never stuffed). Back-to-back words get no extra sync.
//
// Parameters:
//   DATA_W     width of each parallel input word (>= 2)
//   STUFF_LEN  number of consecutive data 1s that forces one stuffed 0
//
// Ports:
//   clock       system clock, rising-edge active
//   reset       asynchronous, active-low reset
//   data_in     parallel word, sampled when data_valid && data_ready
//   data_valid  upstream has a word available
//   data_ready  block accepts data_in this cycle (from registers only)
//   x           serial bit to the NRZI encoder (registered, idles at 1)
//   x_valid     x carries a data, stuff or sync bit (registered)
//   stuffed     x is an inserted stuff bit (registered)
//   busy        state machine is not idle
// ---------------------------------------------------------------------------
module bit_stuff_serializer #(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              x,
  output logic              x_valid,
  output logic              stuffed,
  output logic              busy
);

  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  // One spare count of headroom: after the sync pattern the run can start at 1.
  localparam int ONES_W = $clog2(STUFF_LEN + 2);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ONES_W-1:0] STUFF_AT = ONES_W'(STUFF_LEN);
  localparam logic [ONES_W-1:0] ONE_CNT  = ONES_W'(1);

`ifdef BIT_STUFF_SYNC_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2,
    SYNC  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } state_t;
`endif

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   word_reg, word_next;       // bits not yet sent, at LSB
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next; // index of data bit on x
  logic [ONES_W-1:0]   ones_cnt_reg, ones_cnt_next;
  logic                x_reg, x_next;
  logic                x_valid_reg, x_valid_next;
  logic                stuffed_reg, stuffed_next;
`ifdef BIT_STUFF_SYNC_EN
  logic [2:0]          sync_cnt_reg, sync_cnt_next; // index of sync bit on x
`endif

  logic accept;
  logic last_bit;
  logic stuff_due;
  logic load_word;   // put bit 0 of data_in on x next cycle
  logic next_bit;    // put the next bit of the current word on x next cycle

  assign accept    = data_valid && data_ready;
  assign last_bit  = (bit_cnt_reg == LAST_BIT);
  // >= rather than == keeps the machine safe if a run starts above the limit.
  assign stuff_due = (ones_cnt_reg >= STUFF_AT);

  assign busy    = (state_reg != IDLE);
  assign x       = x_reg;
  assign x_valid = x_valid_reg;
  assign stuffed = stuffed_reg;

  // Ready is derived from registered state only, never from data_valid, so
  // the upstream can hold its word without a combinational loop.
  always_comb begin
    data_ready = 1'b0;
    case (state_reg)
      IDLE:    data_ready = 1'b1;
      SHIFT:   data_ready = last_bit && !stuff_due;
      STUFF:   data_ready = last_bit;
      default: data_ready = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
`ifdef BIT_STUFF_SYNC_EN
          state_next = SYNC;
`else
          state_next = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (stuff_due) begin
          state_next = STUFF;
        end else if (!last_bit || accept) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      STUFF: begin
        if (!last_bit || accept) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
`ifdef BIT_STUFF_SYNC_EN
      SYNC: begin
        if (sync_cnt_reg == 3'd7) begin
          state_next = SHIFT;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic: next values of the registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    word_next     = word_reg;
    bit_cnt_next  = '0;
    ones_cnt_next = '0;     // idle clears the run of 1s
    x_next        = 1'b1;   // idle line level
    x_valid_next  = 1'b0;
    stuffed_next  = 1'b0;
    load_word     = 1'b0;
    next_bit      = 1'b0;
`ifdef BIT_STUFF_SYNC_EN
    sync_cnt_next = '0;
`endif

    case (state_reg)
      IDLE: begin
`ifdef BIT_STUFF_SYNC_EN
        if (accept) begin
          // Hold the full word while the sync pattern goes out.
          word_next    = data_in;
          x_next       = 1'b0;
          x_valid_next = 1'b1;
        end
`else
        load_word = accept;
`endif
      end
      SHIFT: begin
        if (stuff_due) begin
          x_next       = 1'b0;
          x_valid_next = 1'b1;
          stuffed_next = 1'b1;
          bit_cnt_next = bit_cnt_reg;  // stuff belongs after this data bit
        end else if (!last_bit) begin
          next_bit = 1'b1;
        end else begin
          load_word = accept;
        end
      end
      STUFF: begin
        // ones_cnt_reg is zero here, so the run restarts from the next bit.
        if (!last_bit) begin
          next_bit = 1'b1;
        end else begin
          load_word = accept;
        end
      end
`ifdef BIT_STUFF_SYNC_EN
      SYNC: begin
        x_valid_next = 1'b1;
        if (sync_cnt_reg != 3'd7) begin
          sync_cnt_next = sync_cnt_reg + 3'd1;
          // Only the final sync bit is a 1; it seeds the run of 1s.
          x_next        = (sync_cnt_reg == 3'd6);
          ones_cnt_next = (sync_cnt_reg == 3'd6) ? ONE_CNT : '0;
        end else begin
          x_next        = word_reg[0];
          word_next     = word_reg >> 1;
          bit_cnt_next  = '0;
          ones_cnt_next = word_reg[0] ? (ones_cnt_reg + ONE_CNT) : '0;
        end
      end
`endif
      default: ;
    endcase

    if (load_word) begin
      x_next        = data_in[0];
      x_valid_next  = 1'b1;
      word_next     = data_in >> 1;
      bit_cnt_next  = '0;
      // Run of 1s continues across a back-to-back word boundary.
      ones_cnt_next = data_in[0] ? (ones_cnt_reg + ONE_CNT) : '0;
    end

    if (next_bit) begin
      x_next        = word_reg[0];
      x_valid_next  = 1'b1;
      word_next     = word_reg >> 1;
      bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
      ones_cnt_next = word_reg[0] ? (ones_cnt_reg + ONE_CNT) : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_reg     <= '0;
      bit_cnt_reg  <= '0;
      ones_cnt_reg <= '0;
      x_reg        <= 1'b1;
      x_valid_reg  <= 1'b0;
      stuffed_reg  <= 1'b0;
`ifdef BIT_STUFF_SYNC_EN
      sync_cnt_reg <= '0;
`endif
    end else begin
      word_reg     <= word_next;
      bit_cnt_reg  <= bit_cnt_next;
      ones_cnt_reg <= ones_cnt_next;
      x_reg        <= x_next;
      x_valid_reg  <= x_valid_next;
      stuffed_reg  <= stuffed_next;
`ifdef BIT_STUFF_SYNC_EN
      sync_cnt_reg <= sync_cnt_next;
`endif
    end
  end

endmodule
